// File: rtl/hit_serializer.sv
// hit_serializer
//   Buffers multi-lane sample-test bundles (up to MULTI_TEST hits sharing one
//   color) in a DEPTH-entry FIFO and emits them one hit per cycle on a
//   valid/ready stream toward the z-buffer stage.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   hit_R18S          per-lane hit {x, y, depth}, signed
//   color_R18U        bundle color, shared by all lanes
//   hit_valid_R18H    per-lane valid (bundle lane mask)
//   halt_RnnnnL       high while a bundle can be accepted (FIFO not full)
//   hit_R19S          serialized hit
//   color_R19U        color of the serialized hit
//   hit_valid_R19H    serialized hit valid
//   hit_ready_R19H    downstream accepts the current hit
module hit_serializer #(
    parameter int SIGFIG     = 24,
    parameter int RADIX      = 10,
    parameter int AXIS       = 3,
    parameter int COLORS     = 3,
    parameter int MULTI_TEST = 4,
    parameter int DEPTH      = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic signed [MULTI_TEST-1:0][AXIS-1:0][SIGFIG-1:0] hit_R18S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]               color_R18U,
    input  logic        [MULTI_TEST-1:0]                       hit_valid_R18H,
    output logic                                              halt_RnnnnL,
    output logic signed [AXIS-1:0][SIGFIG-1:0]                 hit_R19S,
    output logic        [COLORS-1:0][SIGFIG-1:0]               color_R19U,
    output logic                                              hit_valid_R19H,
    input  logic                                              hit_ready_R19H
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Fraction bits are carried through untouched; only sanity-checked here.
    if (RADIX > SIGFIG) begin : g_bad_radix
        $error("RADIX must not exceed SIGFIG");
    end
    if ((DEPTH < 2) || ((1 << PW) != DEPTH)) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end

    typedef struct packed {
        logic [MULTI_TEST-1:0][AXIS-1:0][SIGFIG-1:0] hit;
        logic [COLORS-1:0][SIGFIG-1:0]               color;
        logic [MULTI_TEST-1:0]                       mask;
    } bundle_t;

    bundle_t               mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0]         count;
    logic [MULTI_TEST-1:0] wmask;      // lanes of the head bundle not yet sent
    logic [MULTI_TEST-1:0] sel_oh;     // lowest set bit of wmask
    logic [MULTI_TEST-1:0] wmask_clr;
    logic                  push, pop, pop_last;
    logic [AXIS-1:0][SIGFIG-1:0] sel_hit;

    assign halt_RnnnnL    = (count < CW'(DEPTH));
    assign hit_valid_R19H = (count != '0);
    assign push           = halt_RnnnnL && (|hit_valid_R18H);
    assign sel_oh         = wmask & (~wmask + MULTI_TEST'(1));
    assign wmask_clr      = wmask & ~sel_oh;
    assign pop            = hit_valid_R19H && hit_ready_R19H;
    assign pop_last       = pop && (wmask_clr == '0);
    assign rd_nxt         = rd_ptr + PW'(1);

    // Storage carries no reset; its contents are only observed while count!=0.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {hit_R18S, color_R18U, hit_valid_R18H};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            wmask  <= '0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + PW'(1);
            if (pop_last) rd_ptr <= rd_nxt;

            case ({push, pop_last})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase

            if (pop_last) begin
                // Next head is either already stored, or (count==1) the
                // bundle arriving on this very edge, or nothing at all.
                if (count > CW'(1))
                    wmask <= mem[rd_nxt].mask;
                else if (push)
                    wmask <= hit_valid_R18H;
                else
                    wmask <= '0;
            end else if (pop) begin
                wmask <= wmask_clr;
            end else if (push && (count == '0)) begin
                wmask <= hit_valid_R18H;
            end
        end
    end

    always_comb begin
        sel_hit = '0;
        for (int i = 0; i < MULTI_TEST; i++)
            if (sel_oh[i]) sel_hit = mem[rd_ptr].hit[i];
    end

    // Outputs are forced to zero when empty so nothing stale leaks after reset.
    assign hit_R19S   = hit_valid_R19H ? sel_hit : '0;
    assign color_R19U = hit_valid_R19H ? mem[rd_ptr].color : '0;

endmodule

// File: doc/hit_serializer.md
# hit_serializer

Buffers the multi-lane sample-test result bundles (up to MULTI_TEST parallel hits sharing one triangle color) and serializes them into a single-hit valid/ready stream for a one-lane z-buffer/fragment stage. It sits between the parallel sample test (stage R18) and the z-buffer (stage R19). It decouples the two: the sample test sees only a halt, and the z-buffer consumes at most one fragment per cycle.

## Interface
- SIGFIG, 24, bits in position/depth/color words
- RADIX, 10, fraction bits (carried through, not interpreted)
- AXIS, 3, axes per hit (x, y, z)
- COLORS, 3, color channels
- MULTI_TEST, 4, parallel hit lanes per bundle (≥1)
- DEPTH, 4, bundle FIFO entries (power of 2, ≥2)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- hit_R18S  in  [MULTI_TEST][AXIS][SIGFIG] signed  per-lane hit x, y, depth
- color_R18U  in  [COLORS][SIGFIG] unsigned  bundle color, shared by all lanes
- hit_valid_R18H  in  [MULTI_TEST]  per-lane hit valid
- halt_RnnnnL  out  1  low stalls upstream; a bundle is accepted only while high
- hit_R19S  out  [AXIS][SIGFIG] signed  serialized hit
- color_R19U  out  [COLORS][SIGFIG] unsigned  color of serialized hit
- hit_valid_R19H  out  1  serialized hit valid
- hit_ready_R19H  in  1  downstream accepts the current hit

## Operation
- Push: on a rising edge with halt_RnnnnL=1 and |hit_valid_R18H=1, write {hit_R18S, color_R18U, lane mask = hit_valid_R18H} at the write pointer. Increment the write pointer and count.
- Bundles with an all-zero mask are dropped: no write, and count is unchanged.
- Head bundle has a working mask, a copy of the stored mask.
- Selected lane = lowest-indexed set bit of the working mask.
- hit_valid_R19H = (count≠0).
- hit_R19S = head.hit[selected lane]; color_R19U = head.color.
- Pop step: on a rising edge with hit_valid_R19H & hit_ready_R19H, clear the selected bit in the working mask.
  - If that bit was the last set bit, pop the bundle: advance the read pointer, decrement count, and load the working mask from the next entry.
- Ordering:
  - Bundles leave in arrival order.
  - Lanes within a bundle leave in ascending index.
  - Nothing is duplicated or lost.
- halt_RnnnnL = (count < DEPTH), combinational from the count register. There is no same-cycle bypass: a push while full is impossible by construction.
- Simultaneous push and pop in one edge: count is unchanged, both pointers advance, and the working mask loads the correct next entry.
  - When count=1, the next entry is the bundle just pushed.
- Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
- No data is interpreted; widths pass through unchanged.
- Upstream holds its bundle stable while halt_RnnnnL=0.
- Downstream must not depend on hit_R19S/color_R19U while hit_valid_R19H=0.

## Timing
- Reset (rst=0, asynchronous):
  - count, pointers and working mask clear to 0.
  - hit_valid_R19H=0, halt_RnnnnL=1, hit_R19S/color_R19U=0.
  - Buffered hits are discarded, including on a reset mid-drain.
  - Release is synchronous to the first rising edge with rst=1.
- Latency: a bundle accepted at edge N has its first hit valid in the cycle after edge N.
- Throughput: one hit per cycle while ready=1. A k-lane bundle drains in k cycles with no bubble between bundles.
- hit_valid_R19H and the output data stay stable while hit_ready_R19H=0.
- Ready is sampled only when valid=1. Ready with valid=0 has no effect.
- All outputs are driven from registers through the lane mux. There are no combinational paths from hit_ready_R19H or hit_valid_R18H to any output.

## Test plan
- Mask 4'b1010, lane1 x=0x000400, lane3 x=0x000C00, ready=1 → valid cycles 1–2 carry lane1 then lane3, both with the bundle color. Valid=0 from cycle 3; halt_RnnnnL stays 1.
- Mask 4'b1111, ready pattern 1,0,1,0,… → exactly 4 hits, lanes 0..3 in order. Data is held unchanged during each ready=0 cycle.
- ready=0, push 4 bundles with mask 4'b0001 → halt_RnnnnL=0 after the 4th edge; the 5th bundle is held upstream and not accepted. Then ready=1 → 4 hits in order; halt_RnnnnL=1 after the first pop; the 5th bundle is accepted next edge and output 5th.
- hit_valid_R18H=4'b0000 with halt_RnnnnL=1 → no write, count stays 0, hit_valid_R19H stays 0.
- count=1 with head mask 4'b0100 and ready=1, plus a new bundle with mask 4'b0011 pushed on the same edge → the following cycles output the new bundle's lane0 then lane1; count never exceeds 1.
- Mask 4'b1111 partly drained (2 hits sent), then rst=0 asynchronously → hit_valid_R19H=0 and halt_RnnnnL=1 immediately. After release, an empty output until the next push.
